// File: rtl/fifo_pkg.sv
// Shared sizing constants and FSM state type for the 32x8 byte FIFO.
package fifo_pkg;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned CAPACITY = DEPTH - 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MID   = 2'd1,
        FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/fifo_32x8_if.sv
// Producer/consumer handshake bundle for fifo_32x8.
interface fifo_32x8_if;
    import fifo_pkg::*;

    logic              clear_n;
    logic              write;
    logic              read;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              f_full_n;
    logic              f_empty_n;
    logic [ADDR_W-1:0] use_dw;

    modport master (
        output clear_n, write, read, data_in,
        input  data_out, f_full_n, f_empty_n, use_dw
    );

    modport slave (
        input  clear_n, write, read, data_in,
        output data_out, f_full_n, f_empty_n, use_dw
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with synchronous write and registered synchronous read.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned W  = WIDTH,
    parameter int unsigned AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2 ** AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_32x8.sv
// Single-clock 32x8 FIFO: pointers, occupancy counter, EMPTY/MID/FULL FSM, sync clear.
// Define FIFO_DEBUG_EN to expose state, pointers and RAM data ports.
module fifo_32x8
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    fifo_32x8_if.slave        bus
`ifdef FIFO_DEBUG_EN
    ,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] countw,
    output logic [ADDR_W-1:0] countr,
    output logic [WIDTH-1:0]  data_in_ram,
    output logic [WIDTH-1:0]  data_out_ram
`endif
);

    fifo_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, rptr_q, cnt_q;
    logic              out_valid_q;
    logic              push, pop;
    logic              ram_we, ram_re;
    logic [WIDTH-1:0]  ram_rdata;

    // At FULL a write is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        unique case (state_q)
            EMPTY: push = bus.write;
            MID: begin
                push = bus.write;
                pop  = bus.read;
            end
            FULL: begin
                push = bus.write && bus.read;
                pop  = bus.read;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = MID;
            MID: begin
                if (pop && !push && cnt_q == ADDR_W'(1)) begin
                    state_d = EMPTY;
                end else if (push && !pop && cnt_q == ADDR_W'(CAPACITY - 1)) begin
                    state_d = FULL;
                end
            end
            FULL: if (pop && !push) state_d = MID;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (!bus.clear_n) begin
            state_q     <= EMPTY;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q      <= rptr_q + 1'b1;
                out_valid_q <= 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign ram_we = push && bus.clear_n;
    assign ram_re = pop && bus.clear_n;

    fifo_ram #(
        .W  (WIDTH),
        .AW (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wptr_q),
        .wdata (bus.data_in),
        .re    (ram_re),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    // RAM output register is not reset; gate it to zero until the first pop after reset/clear.
    assign bus.data_out  = out_valid_q ? ram_rdata : '0;
    assign bus.f_empty_n = (state_q != EMPTY);
    assign bus.f_full_n  = (state_q != FULL);
    assign bus.use_dw    = cnt_q;

`ifdef FIFO_DEBUG_EN
    assign state        = state_q;
    assign countw       = wptr_q;
    assign countr       = rptr_q;
    assign data_in_ram  = bus.data_in;
    assign data_out_ram = ram_rdata;
`endif

endmodule

// File: tb/tb_fifo_32x8.sv
// Directed + randomized bench for fifo_32x8 against a queue-based reference model.
module tb_fifo_32x8;
    import fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;

    logic [7:0] q[$];
    logic [7:0] m_dout;

    fifo_32x8_if bus ();

`ifdef FIFO_DEBUG_EN
    logic [1:0]        dbg_state;
    logic [ADDR_W-1:0] dbg_countw, dbg_countr;
    logic [WIDTH-1:0]  dbg_din_ram, dbg_dout_ram;
`endif

    fifo_32x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_DEBUG_EN
        ,
        .state        (dbg_state),
        .countw       (dbg_countw),
        .countr       (dbg_countr),
        .data_in_ram  (dbg_din_ram),
        .data_out_ram (dbg_dout_ram)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".use_dw"}, 32'(bus.use_dw), 32'(q.size()));
        chk({tag, ".empty_n"}, 32'(bus.f_empty_n), 32'(q.size() != 0));
        chk({tag, ".full_n"}, 32'(bus.f_full_n), 32'(q.size() != CAPACITY));
        chk({tag, ".data_out"}, 32'(bus.data_out), 32'(m_dout));
    endtask

    // One clock of stimulus; the model applies the FIFO rules on the same edge.
    task automatic step(input string tag, input logic w, input logic r, input logic c,
                        input logic [7:0] d);
        bit pop_ok, push_ok;
        @(negedge clk);
        bus.write   = w;
        bus.read    = r;
        bus.clear_n = c;
        bus.data_in = d;
        @(posedge clk);
        if (!c) begin
            q.delete();
            m_dout = 8'h00;
        end else begin
            pop_ok  = r && (q.size() > 0);
            push_ok = w && ((q.size() < CAPACITY) || r);
            if (pop_ok) m_dout = q.pop_front();
            if (push_ok) q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_dout = 8'h00;
        check_all(tag);
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.clear_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        m_dout      = 8'h00;
        rst_n       = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.clear_n = 1'b1;
        bus.data_in = 8'h00;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("rd_empty0", 1'b0, 1'b1, 1'b1, 8'h00);
        step("rd_empty1", 1'b0, 1'b1, 1'b1, 8'h00);

        step("push37", 1'b1, 1'b0, 1'b1, 8'd37);
        step("pop37", 1'b0, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 31; i++) step("fill11", 1'b1, 1'b0, 1'b1, 8'd11);
        step("push_full", 1'b1, 1'b0, 1'b1, 8'd99);
        step("rw_full", 1'b1, 1'b1, 1'b1, 8'd5);
        for (int i = 0; i < 31; i++) step("drain", 1'b0, 1'b1, 1'b1, 8'h00);
        chk("last_is_5", 32'(bus.data_out), 32'd5);

        step("push1", 1'b1, 1'b0, 1'b1, 8'd1);
        step("push2", 1'b1, 1'b0, 1'b1, 8'd2);
        step("push3", 1'b1, 1'b0, 1'b1, 8'd3);
        step("clear", 1'b1, 1'b1, 1'b0, 8'd77);
        step("pop_after_clr", 1'b0, 1'b1, 1'b1, 8'h00);

        step("rw_empty", 1'b1, 1'b1, 1'b1, 8'd42);
        for (int i = 0; i < 20; i++) step("wrap_fill", 1'b1, 1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 33; i++) step("wrap_rw", 1'b1, 1'b1, 1'b1, 8'($urandom));
        reset_pulse("rst_mid");
        step("post_rst_pop", 1'b0, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) != 0);
            if (i == 200) reset_pulse("rst_rand");
            step("rand", w, r, c, 8'($urandom));
        end
        for (int i = 0; i < 32; i++) step("final_drain", 1'b0, 1'b1, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
